// File: rtl/matrix_mem_seq_if.sv
// rtl/matrix_mem_seq_if.sv - row request, response and data-memory signals of the matrix row sequencer
interface matrix_mem_seq_if #(
    parameter int LANES = 4
);
    logic                  req_valid;
    logic                  req_write;
    logic [31:0]           req_addr;
    logic [32*LANES-1:0]   req_wdata;
    logic                  req_ready;
    logic                  stall;
    logic                  resp_valid;
    logic                  resp_err;
    logic [32*LANES-1:0]   resp_rdata;
    logic [31:0]           mem_addr;
    logic [31:0]           mem_wdata;
    logic                  mem_r_en;
    logic                  mem_w_en;
    logic [1:0]            mem_byte_sel;
    logic [31:0]           mem_rdata;

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, mem_rdata,
        output req_ready, stall, resp_valid, resp_err, resp_rdata,
        output mem_addr, mem_wdata, mem_r_en, mem_w_en, mem_byte_sel
    );

    modport master (
        output req_valid, req_write, req_addr, req_wdata, mem_rdata,
        input  req_ready, stall, resp_valid, resp_err, resp_rdata,
        input  mem_addr, mem_wdata, mem_r_en, mem_w_en, mem_byte_sel
    );
endinterface

// File: rtl/matrix_mem_seq.sv
// rtl/matrix_mem_seq.sv - sequences a matrix row load/store into single-word data-memory beats
module matrix_mem_seq #(
    parameter int LANES  = 4,
    parameter int STRIDE = 4
) (
    input  logic           clk,
    input  logic           rst,
    matrix_mem_seq_if.slave bus
);
    localparam int BW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(LANES - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

    state_t                state_q, state_d;
    logic [BW-1:0]         beat_q, beat_d;
    logic                  write_q;
    logic [31:0]           addr_q;
    logic [32*LANES-1:0]   wdata_q;
    logic [32*LANES-1:0]   rdata_q;
    logic                  err_q;

    logic                  accept;
    logic                  misaligned;
    logic                  req_ready_c, stall_c, resp_valid_c, resp_err_c;
    logic                  mem_r_en_c, mem_w_en_c;
    logic [31:0]           mem_addr_c, mem_wdata_c;

    assign accept     = (state_q == IDLE) && bus.req_valid;
    assign misaligned = (bus.req_addr[1:0] != 2'b00);

    // State register and beat counter; reset aborts any transfer in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
        end
    end

    // Next state and all handshake/memory strobes, decoded from the current state
    always_comb begin
        state_d      = state_q;
        beat_d       = beat_q;
        req_ready_c  = 1'b0;
        stall_c      = 1'b0;
        resp_valid_c = 1'b0;
        resp_err_c   = 1'b0;
        mem_r_en_c   = 1'b0;
        mem_w_en_c   = 1'b0;
        mem_addr_c   = 32'h0;
        mem_wdata_c  = 32'h0;
        case (state_q)
            IDLE: begin
                req_ready_c = 1'b1;
                stall_c     = bus.req_valid;
                if (bus.req_valid) begin
                    beat_d  = '0;
                    state_d = misaligned ? DONE : ACCESS;
                end
            end
            ACCESS: begin
                stall_c    = 1'b1;
                // Address arithmetic wraps naturally at 32 bits
                mem_addr_c = addr_q + (32'(beat_q) * 32'(STRIDE));
                if (write_q) begin
                    mem_w_en_c  = 1'b1;
                    mem_wdata_c = wdata_q[32*int'(beat_q) +: 32];
                end else begin
                    mem_r_en_c  = 1'b1;
                end
                if (beat_q == LAST_BEAT) begin
                    // Loads need one more cycle for the last lane's read data
                    state_d = write_q ? DONE : WAIT;
                end else begin
                    beat_d = beat_q + 1'b1;
                end
            end
            WAIT: begin
                stall_c = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                resp_valid_c = 1'b1;
                resp_err_c   = err_q;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Request capture and load-row assembly; read data lags its beat by one cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            write_q <= 1'b0;
            addr_q  <= 32'h0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            if (accept) begin
                write_q <= bus.req_write;
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
                err_q   <= misaligned;
                // Stores leave the last loaded row visible; loads and errors start clean
                if (!bus.req_write || misaligned) begin
                    rdata_q <= '0;
                end
            end
            if (state_q == ACCESS && !write_q && beat_q != '0) begin
                rdata_q[32*(int'(beat_q) - 1) +: 32] <= bus.mem_rdata;
            end
            if (state_q == WAIT) begin
                rdata_q[32*(LANES-1) +: 32] <= bus.mem_rdata;
            end
        end
    end

    assign bus.req_ready    = req_ready_c;
    assign bus.stall        = stall_c;
    assign bus.resp_valid   = resp_valid_c;
    assign bus.resp_err     = resp_err_c;
    assign bus.resp_rdata   = rdata_q;
    assign bus.mem_addr     = mem_addr_c;
    assign bus.mem_wdata    = mem_wdata_c;
    assign bus.mem_r_en     = mem_r_en_c;
    assign bus.mem_w_en     = mem_w_en_c;
    assign bus.mem_byte_sel = 2'b10;
endmodule

// File: tb/tb_matrix_mem_seq.sv
// tb/tb_matrix_mem_seq.sv - scoreboard bench for matrix_mem_seq
module tb_matrix_mem_seq;
    localparam int LANES = 4;
    localparam int W     = 32*LANES;
    localparam int NV    = 10;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } acc_t;

    typedef struct {
        logic         err;
        logic [W-1:0] rdata;
    } rsp_t;

    typedef struct {
        logic         wr;
        logic [31:0]  addr;
        logic [W-1:0] wdata;
        logic         err;
        int           lat;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic mon_en = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   resp_cnt = 0;
    int   last_resp_cyc = 0;

    acc_t exp_acc[$];
    rsp_t exp_rsp[$];
    logic [W-1:0] exp_rdata = '0;
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] dmem    [logic [31:0]];
    vec_t vecs [NV];

    matrix_mem_seq_if #(.LANES(LANES)) bus ();

    matrix_mem_seq #(.LANES(LANES), .STRIDE(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Data memory: read data returns the cycle after mem_r_en
    always @(posedge clk) begin
        if (bus.mem_w_en) dmem[bus.mem_addr] = bus.mem_wdata;
        if (bus.mem_r_en) bus.mem_rdata <= dmem.exists(bus.mem_addr) ? dmem[bus.mem_addr] : 32'h0;
    end

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input logic w, input logic [31:0] a, input logic [W-1:0] d, input logic err);
        logic [31:0] la;
        rsp_t r;
        if (err) begin
            exp_rdata = '0;
        end else begin
            if (!w) exp_rdata = '0;
            for (int k = 0; k < LANES; k++) begin
                la = a + 32'(k*4);
                if (w) begin
                    exp_acc.push_back('{1'b1, la, d[32*k +: 32]});
                    ref_mem[la] = d[32*k +: 32];
                end else begin
                    exp_acc.push_back('{1'b0, la, 32'h0});
                    exp_rdata[32*k +: 32] = ref_mem.exists(la) ? ref_mem[la] : 32'h0;
                end
            end
        end
        r.err   = err;
        r.rdata = exp_rdata;
        exp_rsp.push_back(r);
    endtask

    // Monitor: every memory beat and response is popped against the scoreboard
    acc_t ma;
    rsp_t mr;
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.mem_r_en || bus.mem_w_en) begin
                check("enables_exclusive", W'(bus.mem_r_en & bus.mem_w_en), W'(0));
                if (exp_acc.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_access: got addr 0x%0h, expected no access", bus.mem_addr);
                end else begin
                    ma = exp_acc.pop_front();
                    check("mem_w_en", W'(bus.mem_w_en), W'(ma.we));
                    check("mem_r_en", W'(bus.mem_r_en), W'(!ma.we));
                    check("mem_addr", W'(bus.mem_addr), W'(ma.addr));
                    if (ma.we) check("mem_wdata", W'(bus.mem_wdata), W'(ma.wdata));
                end
            end else begin
                check("idle_mem_addr", W'(bus.mem_addr), W'(0));
                check("idle_mem_wdata", W'(bus.mem_wdata), W'(0));
            end
            check("stall", W'(bus.stall), W'(bus.req_ready ? bus.req_valid : !bus.resp_valid));
            if (bus.resp_valid) begin
                resp_cnt++;
                last_resp_cyc = cyc;
                if (exp_rsp.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_resp: got resp_valid 1, expected 0");
                end else begin
                    mr = exp_rsp.pop_front();
                    check("resp_err", W'(bus.resp_err), W'(mr.err));
                    check("resp_rdata", bus.resp_rdata, mr.rdata);
                end
            end
        end
    end

    task automatic issue_req(input logic w, input logic [31:0] a, input logic [W-1:0] d,
                             input logic err, output int acc_cyc, output int start_cnt);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b1;
        bus.req_write = w;
        bus.req_addr  = a;
        bus.req_wdata = d;
        push_exp(w, a, d, err);
        start_cnt = resp_cnt;
        @(negedge clk);
        #1;
        acc_cyc = cyc;
        check("req_ready_idle", W'(bus.req_ready), W'(1));
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.req_write = 1'($urandom);
        bus.req_addr  = $urandom;
        bus.req_wdata = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic finish_req(input int start_cnt, input int acc_cyc, input int exp_lat);
        int got = 0;
        for (int t = 0; t < 40; t++) begin
            @(posedge clk);
            if (resp_cnt > start_cnt) begin
                got = 1;
                break;
            end
        end
        if (got == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL resp_timeout: got no resp_valid, expected one within 40 cycles");
        end else begin
            check("latency", W'(last_resp_cyc - acc_cyc), W'(exp_lat));
        end
    endtask

    initial begin
        int acc, st, found, lows, rdy, a1;

        vecs[0] = '{1'b1, 32'h0000_0100, {32'h44, 32'h33, 32'h22, 32'h11}, 1'b0, LANES+1};
        vecs[1] = '{1'b0, 32'h0000_0100, '0, 1'b0, LANES+2};
        vecs[2] = '{1'b0, 32'h0000_0102, '0, 1'b1, 1};
        vecs[3] = '{1'b1, 32'hFFFF_FFF8, {32'hDDDD_0004, 32'hCCCC_0000, 32'hBBBB_FFFC, 32'hAAAA_FFF8}, 1'b0, LANES+1};
        vecs[4] = '{1'b0, 32'hFFFF_FFF8, '0, 1'b0, LANES+2};
        vecs[5] = '{1'b1, 32'h0000_0200, {$urandom, $urandom, $urandom, $urandom}, 1'b0, LANES+1};
        vecs[6] = '{1'b0, 32'h0000_0201, '0, 1'b1, 1};
        vecs[7] = '{1'b0, 32'h0000_0200, '0, 1'b0, LANES+2};
        vecs[8] = '{1'b1, 32'h0000_0104, {$urandom, $urandom, $urandom, $urandom}, 1'b0, LANES+1};
        vecs[9] = '{1'b0, 32'h0000_0100, '0, 1'b0, LANES+2};

        // Reset with a request pending: reset wins, DUT stays in IDLE
        bus.mem_rdata = 32'h0;
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = 32'h100;
        bus.req_wdata = '1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", W'(bus.req_ready), W'(1));
        check("rst_mem_r_en", W'(bus.mem_r_en), W'(0));
        check("rst_mem_w_en", W'(bus.mem_w_en), W'(0));
        check("rst_mem_addr", W'(bus.mem_addr), W'(0));
        check("rst_resp_valid", W'(bus.resp_valid), W'(0));
        check("rst_resp_rdata", bus.resp_rdata, W'(0));
        check("rst_byte_sel", W'(bus.mem_byte_sel), W'(2'b10));
        check("rst_stall_idle_valid", W'(bus.stall), W'(1));
        bus.req_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        mon_en = 1'b1;

        for (int i = 0; i < NV; i++) begin
            issue_req(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].err, acc, st);
            finish_req(st, acc, vecs[i].lat);
        end

        // Reset during beat 2 of a load aborts it with no response
        issue_req(1'b0, 32'h100, '0, 1'b0, acc, st);
        found = 0;
        for (int t = 0; t < 10; t++) begin
            if (bus.mem_r_en && bus.mem_addr == 32'h108) begin
                found = 1;
                break;
            end
            @(posedge clk);
            #2;
        end
        check("abort_beat2_seen", W'(found), W'(1));
        rst = 1'b1;
        @(negedge clk);
        #1;
        exp_acc.delete();
        exp_rsp.delete();
        exp_rdata = '0;
        @(negedge clk);
        #1;
        check("abort_req_ready", W'(bus.req_ready), W'(1));
        check("abort_mem_r_en", W'(bus.mem_r_en), W'(0));
        check("abort_mem_w_en", W'(bus.mem_w_en), W'(0));
        check("abort_resp_valid", W'(bus.resp_valid), W'(0));
        check("abort_rdata_cleared", bus.resp_rdata, W'(0));
        rst = 1'b0;
        for (int t = 0; t < 4; t++) begin
            @(negedge clk);
            #1;
            check("abort_no_resp", W'(bus.resp_valid), W'(0));
        end

        // A store after the abort reports the cleared row
        issue_req(1'b1, 32'h400, {32'h4, 32'h3, 32'h2, 32'h1}, 1'b0, acc, st);
        finish_req(st, acc, LANES+1);

        // Back-to-back: req_valid held high, second request changes fields after first accept
        @(posedge clk);
        #1;
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = 32'h300;
        bus.req_wdata = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
        push_exp(1'b1, 32'h300, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 1'b0);
        st = resp_cnt;
        @(negedge clk);
        #1;
        a1 = cyc;
        @(posedge clk);
        #1;
        bus.req_write = 1'b0;
        bus.req_addr  = 32'h300;
        bus.req_wdata = '0;
        push_exp(1'b0, 32'h300, '0, 1'b0);
        lows = 0;
        rdy  = -1;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            #1;
            if (bus.resp_valid) check("b2b_first_latency", W'(cyc - a1), W'(LANES+1));
            if (!bus.stall) lows++;
            if (bus.req_ready) begin
                rdy = cyc;
                break;
            end
        end
        check("b2b_accept_cycle", W'(rdy - a1), W'(LANES+2));
        check("b2b_stall_low_cycles", W'(lows), W'(1));
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        finish_req(st + 1, rdy, LANES+2);

        repeat (3) @(posedge clk);
        check("acc_queue_empty", W'(exp_acc.size()), W'(0));
        check("rsp_queue_empty", W'(exp_rsp.size()), W'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/matrix_mem_seq.md
MATRIX_MEM_SEQ -- requirements
Module: matrix_mem_seq

Interface
REQ-001 SHALL have parameter LANES, default 4, meaning number of 32-bit lanes per matrix row.
REQ-002 SHALL have parameter STRIDE, default 4, meaning the byte increment between consecutive lane addresses.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  1  matrix row load/store request from the MEM stage.
REQ-006 req_write  input  1  1 = store row, 0 = load row.
REQ-007 req_addr  input  32  byte base address of the row.
REQ-008 req_wdata  input  32*LANES  row to store; lane k occupies bits [32k+31:32k].
REQ-009 req_ready  output  1  request accepted this cycle when high together with req_valid.
REQ-010 stall  output  1  freezes the pipeline while a row transfer is outstanding.
REQ-011 resp_valid  output  1  one-cycle pulse marking transfer completion.
REQ-012 resp_err  output  1  qualifies resp_valid; misaligned request, no memory access performed.
REQ-013 resp_rdata  output  32*LANES  assembled load row; valid with resp_valid on loads.
REQ-014 mem_addr  output  32  word address to the data memory.
REQ-015 mem_wdata  output  32  store word to the data memory.
REQ-016 mem_r_en / mem_w_en  output  1 each  data memory read/write enables, never both high.
REQ-017 mem_byte_sel  output  2  constant 2'b10 (word access).
REQ-018 mem_rdata  input  32  data memory read data, valid the cycle after mem_r_en with the corresponding address.

Function
REQ-019 SHALL implement states IDLE, ACCESS, WAIT, DONE in a registered state machine.
REQ-020 req_ready SHALL equal (state == IDLE).
REQ-021 In IDLE with req_valid: capture req_write, req_addr, req_wdata, clear beat counter; if req_addr[1:0] != 0 go DONE with err flag set, else go ACCESS.
REQ-022 ACCESS beat k (0..LANES-1): mem_addr = base + k*STRIDE, modulo 2^32 (wrap-around, no error).
REQ-023 ACCESS store: mem_w_en = 1, mem_wdata = captured lane k; mem_r_en = 0.
REQ-024 ACCESS load: mem_r_en = 1, mem_w_en = 0; mem_rdata in the following cycle SHALL be written into resp_rdata lane k.
REQ-025 After beat LANES-1: store goes DONE; load goes WAIT, which captures the final lane, then DONE.
REQ-026 In IDLE, WAIT and DONE: mem_r_en = mem_w_en = 0, mem_addr and mem_wdata = 0.
REQ-027 DONE: resp_valid = 1 for exactly one cycle, resp_err = err flag; then IDLE unconditionally.
REQ-028 Latency from accept edge to resp_valid: store LANES+1 cycles, load LANES+2 cycles, misaligned 1 cycle.
REQ-029 stall SHALL be combinational: high when (state == IDLE and req_valid) or state in {ACCESS, WAIT}; low in DONE.
REQ-030 req_valid outside IDLE SHALL be ignored; inputs are sampled only on the accept cycle.
REQ-031 Back-to-back: a request presented in the cycle after DONE SHALL be accepted; no request is accepted in DONE.
REQ-032 resp_rdata SHALL hold its value until the next load begins (cleared on accept of a load) and SHALL be unchanged by stores.
REQ-033 On misaligned requests, resp_rdata SHALL be all zeros.

Reset
REQ-034 On rst, next edge: state = IDLE, beat counter = 0, err flag = 0, resp_rdata = 0, resp_valid = resp_err = 0, all mem outputs 0.
REQ-035 rst during ACCESS/WAIT SHALL abort the transfer: no further mem enables and no resp_valid; rst takes priority over req_valid.

Verification
REQ-036 Store addr 0x100, wdata lanes {0x11,0x22,0x33,0x44} -> mem_w_en for 4 cycles at 0x100/0x104/0x108/0x10C with 0x11..0x44; resp_valid at cycle 5, resp_err = 0.
REQ-037 Load addr 0x100 after that store -> mem_r_en for 4 cycles; resp_valid at cycle 6 with resp_rdata = {0x44,0x33,0x22,0x11} (lane 3..0).
REQ-038 Load addr 0x102 -> no mem enables; resp_valid and resp_err = 1 on the next cycle; resp_rdata = 0.
REQ-039 Store addr 0xFFFFFFF8 -> addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000, 0x00000004; resp_err = 0.
REQ-040 rst asserted at beat 2 of a load -> next cycle IDLE, enables 0, req_ready = 1, no resp_valid pulse.
REQ-041 req_valid held high across two requests -> second accepted exactly one cycle after the first DONE; stall low only in DONE cycle.
